// File: rtl/io_port_buffer_if.sv
// Datapath I/O port bundle: producer side, Datapath read/write ports, consumer side.
interface io_port_buffer_if #(
  parameter int unsigned WORD_WIDTH = 36
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] io_read_data;
  logic                  io_read_EF;
  logic                  io_rden;
  logic [WORD_WIDTH-1:0] io_write_data;
  logic                  io_wren;
  logic                  io_write_EF;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overrun;

  // Environment side: producer, Datapath and consumer.
  modport master (
    output in_data, in_valid, io_rden, io_write_data, io_wren, out_ready,
    input  in_ready, io_read_data, io_read_EF, io_write_EF, out_data, out_valid, overrun
  );

  // Buffer side.
  modport slave (
    input  in_data, in_valid, io_rden, io_write_data, io_wren, out_ready,
    output in_ready, io_read_data, io_read_EF, io_write_EF, out_data, out_valid, overrun
  );
endinterface

// File: rtl/io_port_buffer.sv
// Single Datapath I/O port buffer: a read FIFO (producer -> Datapath) and a write FIFO
// (Datapath -> consumer), plus a sticky overrun flag for illegal port accesses.
module io_port_buffer #(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  io_port_buffer_if.slave bus
);
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  // Read FIFO state
  logic [WORD_WIDTH-1:0] rmem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  rcount;
  logic [CNT_WIDTH-1:0]  rcount_nxt;
  logic                  r_push;
  logic                  r_pop;

  // Write FIFO state
  logic [WORD_WIDTH-1:0] wmem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;
  logic [CNT_WIDTH-1:0]  wcount;
  logic [CNT_WIDTH-1:0]  wcount_nxt;
  logic                  w_push;
  logic                  w_pop;

  logic                  err_c;

  // Handshake qualification; flags are flops, so no input reaches an output combinationally.
  always_comb begin
    r_push     = bus.in_valid & bus.in_ready;
    r_pop      = bus.io_rden & bus.io_read_EF;
    w_push     = bus.io_wren & ~bus.io_write_EF;
    w_pop      = bus.out_valid & bus.out_ready;
    rcount_nxt = rcount + CNT_WIDTH'(r_push) - CNT_WIDTH'(r_pop);
    wcount_nxt = wcount + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
    err_c      = (bus.io_rden & ~bus.io_read_EF) | (bus.io_wren & bus.io_write_EF);
  end

  // Read FIFO storage, pointers, count and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) rmem[i] <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      rcount         <= '0;
      bus.in_ready   <= 1'b1;
      bus.io_read_EF <= 1'b0;
    end else begin
      if (r_push) begin
        rmem[r_wr_ptr] <= bus.in_data;
        r_wr_ptr       <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (r_pop) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      rcount         <= rcount_nxt;
      bus.in_ready   <= (rcount_nxt != CNT_FULL);
      bus.io_read_EF <= (rcount_nxt != '0);
    end
  end

  // Write FIFO storage, pointers, count and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) wmem[i] <= '0;
      w_wr_ptr        <= '0;
      w_rd_ptr        <= '0;
      wcount          <= '0;
      bus.io_write_EF <= 1'b0;
      bus.out_valid   <= 1'b0;
    end else begin
      if (w_push) begin
        wmem[w_wr_ptr] <= bus.io_write_data;
        w_wr_ptr       <= w_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_pop) w_rd_ptr <= w_rd_ptr + ADDR_WIDTH'(1);
      wcount          <= wcount_nxt;
      bus.io_write_EF <= (wcount_nxt == CNT_FULL);
      bus.out_valid   <= (wcount_nxt != '0);
    end
  end

  // Sticky overrun: set by any access to a port that is not ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) bus.overrun <= 1'b0;
    else          bus.overrun <= bus.overrun | err_c;
  end

  // Head words come straight from the flop arrays at registered pointers.
  assign bus.io_read_data = rmem[r_rd_ptr];
  assign bus.out_data     = wmem[w_rd_ptr];
endmodule

// File: tb/tb_io_port_buffer.sv
// Directed bench for io_port_buffer with queue scoreboards for both FIFOs.
module tb_io_port_buffer;
  localparam int unsigned WW    = 36;
  localparam int unsigned DEPTH = 4;

  logic clock;
  logic reset_n;
  io_port_buffer_if #(.WORD_WIDTH(WW)) bus ();

  io_port_buffer #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int tests_run;
  int tests_failed;
  logic [WW-1:0] rd_q[$];
  logic [WW-1:0] wr_q[$];
  logic ov_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard model.
  task automatic chk_all(input string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(rd_q.size() < DEPTH));
    chk({tag, " read_EF"}, 64'(bus.io_read_EF), 64'(rd_q.size() > 0));
    if (rd_q.size() > 0) chk({tag, " read_data"}, 64'(bus.io_read_data), 64'(rd_q[0]));
    chk({tag, " write_EF"}, 64'(bus.io_write_EF), 64'(wr_q.size() == DEPTH));
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(wr_q.size() > 0));
    if (wr_q.size() > 0) chk({tag, " out_data"}, 64'(bus.out_data), 64'(wr_q[0]));
    chk({tag, " overrun"}, 64'(bus.overrun), 64'(ov_m));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rst in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, " rst read_EF"}, 64'(bus.io_read_EF), 64'(0));
    chk({tag, " rst read_data"}, 64'(bus.io_read_data), 64'(0));
    chk({tag, " rst write_EF"}, 64'(bus.io_write_EF), 64'(0));
    chk({tag, " rst out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, " rst out_data"}, 64'(bus.out_data), 64'(0));
    chk({tag, " rst overrun"}, 64'(bus.overrun), 64'(0));
  endtask

  // Advance one edge, updating the model from the inputs driven before it.
  task automatic cycle(input string tag);
    bit rpush, rpop, wpush, wpop;
    rpush = bus.in_valid && (rd_q.size() < DEPTH);
    rpop  = bus.io_rden && (rd_q.size() > 0);
    wpush = bus.io_wren && (wr_q.size() < DEPTH);
    wpop  = bus.out_ready && (wr_q.size() > 0);
    if ((bus.io_rden && rd_q.size() == 0) || (bus.io_wren && wr_q.size() == DEPTH)) ov_m = 1'b1;
    if (rpop)  void'(rd_q.pop_front());
    if (rpush) rd_q.push_back(bus.in_data);
    if (wpop)  void'(wr_q.pop_front());
    if (wpush) wr_q.push_back(bus.io_write_data);
    @(posedge clock);
    #1;
    chk_all(tag);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    ov_m = 1'b0;
    clock = 1'b0;
    reset_n = 1'b0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.io_rden = 1'b0;
    bus.io_write_data = '0;
    bus.io_wren = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk_reset("init");
    reset_n = 1'b1;

    // 1: push 1,2,3 then pop three times
    bus.in_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      bus.in_data = WW'(w);
      cycle("t1 push");
    end
    bus.in_valid = 1'b0;
    bus.io_rden = 1'b1;
    repeat (3) cycle("t1 pop");
    bus.io_rden = 1'b0;

    // 2: fill to full, one pop unblocks the fifth word
    bus.in_valid = 1'b1;
    for (int w = 10; w <= 14; w++) begin
      bus.in_data = WW'(w);
      cycle("t2 fill");
    end
    bus.io_rden = 1'b1;
    cycle("t2 pop full");
    bus.io_rden = 1'b0;
    cycle("t2 accept 14");
    bus.in_valid = 1'b0;
    bus.io_rden = 1'b1;
    repeat (4) cycle("t2 drain");
    bus.io_rden = 1'b0;

    // 3: simultaneous push/pop at count 2 across pointer wrap
    bus.in_valid = 1'b1;
    for (int w = 20; w <= 21; w++) begin
      bus.in_data = WW'(w);
      cycle("t3 prime");
    end
    bus.io_rden = 1'b1;
    for (int w = 22; w <= 29; w++) begin
      bus.in_data = WW'(w);
      cycle("t3 both");
    end
    bus.in_valid = 1'b0;
    repeat (2) cycle("t3 drain");
    bus.io_rden = 1'b0;

    // 4: write FIFO fill while blocked, then drain
    bus.io_wren = 1'b1;
    for (int w = 10; w <= 13; w++) begin
      bus.io_write_data = WW'(w);
      cycle("t4 write");
    end
    bus.io_wren = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cycle("t4 drain");
    bus.out_ready = 1'b0;

    // 5: illegal read, legal traffic, then illegal write when full
    bus.io_rden = 1'b1;
    cycle("t5 bad rden");
    bus.io_rden = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = WW'(5);
    cycle("t5 legal push");
    bus.in_valid = 1'b0;
    bus.io_rden = 1'b1;
    cycle("t5 legal pop");
    bus.io_rden = 1'b0;
    bus.io_wren = 1'b1;
    for (int w = 40; w <= 44; w++) begin
      bus.io_write_data = WW'(w);
      cycle("t5 wren full");
    end
    bus.io_wren = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cycle("t5 drain");
    bus.out_ready = 1'b0;

    // 6: reset mid-stream between edges
    bus.in_valid = 1'b1;
    bus.io_wren = 1'b1;
    for (int w = 60; w <= 61; w++) begin
      bus.in_data = WW'(w);
      bus.io_write_data = WW'(w + 8);
      cycle("t6 load");
    end
    bus.in_valid = 1'b0;
    bus.io_wren = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("t6 async");
    rd_q.delete();
    wr_q.delete();
    ov_m = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = WW'(7);
    cycle("t6 push 7");
    bus.in_valid = 1'b0;
    chk("t6 data 7", 64'(bus.io_read_data), 64'(7));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
